// File: rtl/dms_ctrl_pkg.sv
// Shared types for the DMS loop-filter acquisition controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dms_ctrl_pkg;

    localparam int ICP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_ACQUIRE   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_TRACK     = 3'd4
    } dms_lpf_state_t;

endpackage

// File: rtl/dms_lpf_ctrl_if.sv
// Bundle between phase detector / charge pump side and the loop-filter controller.
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface dms_lpf_ctrl_if;
    import dms_ctrl_pkg::*;

    logic             en;
    logic             up;
    logic             dn;
    logic             pchg_en;
    logic [ICP_W-1:0] icp_code;
    logic             cp_en;
    logic             locked;
    logic [2:0]       state_o;

    modport master (
        output en, up, dn,
        input  pchg_en, icp_code, cp_en, locked, state_o
    );

    modport slave (
        input  en, up, dn,
        output pchg_en, icp_code, cp_en, locked, state_o
    );
endinterface

// File: rtl/dms_lpf_win_acc.sv
// UP/DN balance window: counts WIN_LEN cycles and accumulates signed UP-DN.
// Latency: win_end/win_abs are combinational in the last window cycle and include that cycle's sample.
// Backpressure: none; one up/dn sample consumed per cycle while run is high.
module dms_lpf_win_acc #(
    parameter int WIN_LEN = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic                           restart,
    input  logic                           up,
    input  logic                           dn,
    output logic                           win_end,
    output logic [$clog2(WIN_LEN)+1:0]     win_abs
);
    localparam int CNT_W = $clog2(WIN_LEN);
    localparam int ACC_W = $clog2(WIN_LEN) + 2;

    logic        [CNT_W-1:0] win_cnt;
    logic signed [ACC_W-1:0] diff;
    logic signed [ACC_W-1:0] delta;
    logic signed [ACC_W-1:0] diff_sum;

    // Per-cycle step, running sum including this cycle, and window-end magnitude
    always_comb begin
        delta = '0;
        if (up && !dn) begin
            delta = ACC_W'(1);
        end else if (dn && !up) begin
            delta = '1;
        end
        diff_sum = diff + delta;
        win_end  = run && (win_cnt == CNT_W'(WIN_LEN - 1));
        win_abs  = diff_sum[ACC_W-1] ? -diff_sum : diff_sum;
    end

    // Window counter and accumulator; cleared when idle, on restart and after each window end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            diff    <= '0;
        end else if (!run || restart || win_end) begin
            win_cnt <= '0;
            diff    <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            diff    <= diff_sum;
        end
    end
endmodule

// File: rtl/dms_lpf_ctrl.sv
// Acquisition/gear-shift sequencer: precharge, high-gain acquire, step-down, track with lock flag.
// Latency: all outputs registered, reflecting the state entered on the causing clock edge.
// Backpressure: none; up/dn sampled every cycle, en is level-sensitive.
module dms_lpf_ctrl
    import dms_ctrl_pkg::*;
#(
    parameter int               PRECHG_CYC = 256,
    parameter int               WIN_LEN    = 64,
    parameter int               LOCK_THR   = 4,
    parameter int               LOCK_WINS  = 8,
    parameter int               UNLOCK_THR = 16,
    parameter logic [ICP_W-1:0] ICP_ACQ    = 4'hF,
    parameter logic [ICP_W-1:0] ICP_TRK    = 4'h4
) (
    input  logic           clk,
    input  logic           rst_n,
    dms_lpf_ctrl_if.slave  bus
);
    localparam int ACC_W = $clog2(WIN_LEN) + 2;
    localparam int PC_W  = $clog2(PRECHG_CYC);
    localparam int GC_W  = $clog2(LOCK_WINS + 1);

    dms_lpf_state_t   state, state_nxt;
    logic [ICP_W-1:0] icp_code, icp_nxt, icp_dec;
    logic [PC_W-1:0]  pc_cnt, pc_nxt;
    logic [GC_W-1:0]  good_cnt, good_nxt, good_inc;
    logic             pchg_en, cp_en, locked;
    logic             win_end, win_good, win_lost, run, restart;
    logic [ACC_W-1:0] win_abs;

    assign run     = (state == ST_ACQUIRE) || (state == ST_SHIFT) || (state == ST_TRACK);
    assign restart = (state_nxt == ST_ACQUIRE) && (state != ST_ACQUIRE);

    dms_lpf_win_acc #(.WIN_LEN(WIN_LEN)) u_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .restart (restart),
        .up      (bus.up),
        .dn      (bus.dn),
        .win_end (win_end),
        .win_abs (win_abs)
    );

    assign win_good = (win_abs <= ACC_W'(LOCK_THR));
    assign win_lost = (win_abs >  ACC_W'(UNLOCK_THR));
    assign icp_dec  = icp_code - 1'b1;
    assign good_inc = (good_cnt == GC_W'(LOCK_WINS)) ? good_cnt : good_cnt + 1'b1;

    // Next-state, gain code and counter updates; en low overrides everything back to idle
    always_comb begin
        state_nxt = state;
        icp_nxt   = icp_code;
        pc_nxt    = pc_cnt;
        good_nxt  = good_cnt;
        case (state)
            ST_IDLE: begin
                if (bus.en) begin
                    state_nxt = ST_PRECHARGE;
                    pc_nxt    = '0;
                end
            end
            ST_PRECHARGE: begin
                if (pc_cnt == PC_W'(PRECHG_CYC - 1)) begin
                    state_nxt = ST_ACQUIRE;
                    icp_nxt   = ICP_ACQ;
                    good_nxt  = '0;
                end else begin
                    pc_nxt = pc_cnt + 1'b1;
                end
            end
            ST_ACQUIRE: begin
                icp_nxt = ICP_ACQ;
                if (win_end) begin
                    if (win_good) begin
                        good_nxt = good_inc;
                        if (good_inc == GC_W'(LOCK_WINS)) begin
                            state_nxt = ST_SHIFT;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            ST_SHIFT: begin
                if (win_end) begin
                    if (win_good) begin
                        icp_nxt = icp_dec;
                        if (icp_dec == ICP_TRK) begin
                            state_nxt = ST_TRACK;
                        end
                    end else begin
                        state_nxt = ST_ACQUIRE;
                        icp_nxt   = ICP_ACQ;
                        good_nxt  = '0;
                    end
                end
            end
            ST_TRACK: begin
                icp_nxt = ICP_TRK;
                if (win_end && win_lost) begin
                    state_nxt = ST_ACQUIRE;
                    icp_nxt   = ICP_ACQ;
                    good_nxt  = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_nxt = ST_IDLE;
            pc_nxt    = '0;
            good_nxt  = '0;
        end
        // The charge pump code is only meaningful while the pump runs
        if ((state_nxt == ST_IDLE) || (state_nxt == ST_PRECHARGE)) begin
            icp_nxt = '0;
        end
    end

    // State, counters and output registers, all updated from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            icp_code <= '0;
            pc_cnt   <= '0;
            good_cnt <= '0;
            pchg_en  <= 1'b0;
            cp_en    <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            icp_code <= icp_nxt;
            pc_cnt   <= pc_nxt;
            good_cnt <= good_nxt;
            pchg_en  <= (state_nxt == ST_PRECHARGE);
            cp_en    <= (state_nxt == ST_ACQUIRE) || (state_nxt == ST_SHIFT) ||
                        (state_nxt == ST_TRACK);
            locked   <= (state_nxt == ST_TRACK);
        end
    end

    assign bus.pchg_en  = pchg_en;
    assign bus.icp_code = icp_code;
    assign bus.cp_en    = cp_en;
    assign bus.locked   = locked;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_dms_lpf_ctrl.sv
// Directed bench for the DMS loop-filter controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_dms_lpf_ctrl;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dms_lpf_ctrl_if bus ();

    dms_lpf_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {state, pchg_en, icp_code, cp_en, locked}
    function automatic logic [9:0] ex(input logic [2:0] st, input logic pc,
                                      input logic [3:0] icp, input logic cp, input logic lk);
        return {st, pc, icp, cp, lk};
    endfunction

    task automatic chk(input string tag, input logic [9:0] expv);
        logic [9:0] obs;
        obs = {bus.state_o, bus.pchg_en, bus.icp_code, bus.cp_en, bus.locked};
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed {st,pchg,icp,cp,lk}=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 64-cycle window: |net| excess pulses first, then a background pattern
    // bg 0: quiet, 1: up and dn both high, 2: alternating up/dn
    task automatic win(input int net, input int bg);
        int a;
        a = (net < 0) ? -net : net;
        for (int i = 0; i < 64; i++) begin
            if (i < a) begin
                bus.up = (net > 0);
                bus.dn = (net < 0);
            end else if (bg == 0) begin
                bus.up = 1'b0;
                bus.dn = 1'b0;
            end else if (bg == 1) begin
                bus.up = 1'b1;
                bus.dn = 1'b1;
            end else begin
                bus.up = ((i % 2) == 1);
                bus.dn = ((i % 2) == 0);
            end
            @(posedge clk);
            #1;
        end
        bus.up = 1'b0;
        bus.dn = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.up = 1'b0;
        bus.dn = 1'b0;
        #2;
        chk("reset", ex(3'd0, 1'b0, 4'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);
        chk("idle_en_low", ex(3'd0, 1'b0, 4'h0, 1'b0, 1'b0));

        // Precharge lasts exactly 256 cycles
        bus.en = 1'b1;
        step(1);
        chk("prechg_entry", ex(3'd1, 1'b1, 4'h0, 1'b0, 1'b0));
        step(255);
        chk("prechg_last", ex(3'd1, 1'b1, 4'h0, 1'b0, 1'b0));
        step(1);
        chk("acq_entry", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));

        // Alternating up/dn: 8 good windows then one step per window
        for (int k = 0; k < 7; k++) win(0, 2);
        chk("acq_7_good", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));
        win(0, 2);
        chk("shift_entry", ex(3'd3, 1'b0, 4'hF, 1'b1, 1'b0));
        for (int k = 1; k <= 6; k++) begin
            win(0, 2);
            chk($sformatf("shift_step_%0d", k), ex(3'd3, 1'b0, 4'(15 - k), 1'b1, 1'b0));
        end
        // At icp=9 a window with net 10 UP falls back to acquire
        win(10, 0);
        chk("shift_bad_net10", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));

        // Net 4 is still good, net -5 is bad and clears the good-window count
        for (int k = 0; k < 3; k++) win(4, 0);
        win(-5, 0);
        for (int k = 0; k < 7; k++) win(0, 0);
        chk("acq_goodcnt_cleared", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));
        win(0, 0);
        chk("shift_entry2", ex(3'd3, 1'b0, 4'hF, 1'b1, 1'b0));
        for (int k = 0; k < 10; k++) win(0, 1);
        chk("shift_icp5", ex(3'd3, 1'b0, 4'h5, 1'b1, 1'b0));
        win(0, 1);
        chk("track_entry", ex(3'd4, 1'b0, 4'h4, 1'b1, 1'b1));

        // Track: up to 16 net either way keeps lock, 17 drops it
        win(10, 0);
        chk("track_net10", ex(3'd4, 1'b0, 4'h4, 1'b1, 1'b1));
        win(-16, 0);
        chk("track_net_m16", ex(3'd4, 1'b0, 4'h4, 1'b1, 1'b1));
        win(17, 0);
        chk("track_net17", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));

        // up=dn=1 every cycle counts as balanced all the way to lock
        for (int k = 0; k < 18; k++) win(0, 1);
        chk("both_shift_icp5", ex(3'd3, 1'b0, 4'h5, 1'b1, 1'b0));
        win(0, 1);
        chk("both_track", ex(3'd4, 1'b0, 4'h4, 1'b1, 1'b1));

        // Asynchronous reset mid-track clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", ex(3'd0, 1'b0, 4'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        chk("restart_prechg", ex(3'd1, 1'b1, 4'h0, 1'b0, 1'b0));
        step(260);
        chk("restart_acq", ex(3'd2, 1'b0, 4'hF, 1'b1, 1'b0));

        // en low returns to idle next cycle; re-enable restarts precharge
        bus.en = 1'b0;
        step(1);
        chk("en_low_idle", ex(3'd0, 1'b0, 4'h0, 1'b0, 1'b0));
        bus.en = 1'b1;
        step(1);
        chk("reenable_prechg", ex(3'd1, 1'b1, 4'h0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
